// File: rtl/booth_digit_sequencer.sv
// Serial controller for the radix-4 Booth recoder: issues one 2-bit slice per cycle,
// chains the recoder carry, appends a correction digit and frames the recoded digit stream.
module booth_digit_sequencer #(
  parameter int N  = 8,
  parameter int IW = $clog2(N/2+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_signed,
  input  logic [N-1:0]  mult,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic [1:0]    rc_m,
  output logic          rc_c_in,
  input  logic          rc_c_out,
  input  logic          rc_one,
  input  logic          rc_neg,
  input  logic          rc_zero,
  output logic          dig_valid,
  output logic          dig_one,
  output logic          dig_neg,
  output logic          dig_zero,
  output logic [IW-1:0] dig_idx,
  output logic          dig_last,
  output logic          done
);

  localparam int ND = N/2;
  localparam logic [IW-1:0] LAST_IDX = IW'(ND-1);

  typedef enum logic [1:0] {IDLE, ISSUE, EXTRA, DRAIN} state_t;

  state_t        state;
  logic [N-1:0]  sh;
  logic          carry;
  logic          mode_signed;
  logic [IW-1:0] cnt;
  logic          last_slice;
  logic          need_fix;

  // The final carry cf leaves the digit sum at unsigned(mult) - cf*2^N; a correction
  // digit is needed whenever that differs from the value the mode asks for.
  always_comb begin
    last_slice = (state == ISSUE) && (cnt == LAST_IDX);
    need_fix   = mode_signed ? (!rc_c_out && sh[1]) : rc_c_out;
  end

  assign rc_c_in  = carry;
  assign busy     = !ready;
  assign dig_one  = rc_one;
  assign dig_neg  = rc_neg;
  assign dig_zero = rc_zero;

  // NOTE: every register here is updated with <= so all next-state terms read the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      sh          <= '0;
      carry       <= 1'b0;
      mode_signed <= 1'b0;
      cnt         <= '0;
      rc_m        <= 2'b00;
      dig_valid   <= 1'b0;
      dig_idx     <= '0;
      dig_last    <= 1'b0;
      done        <= 1'b0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      ready     <= 1'b1;
      carry     <= 1'b0;
      rc_m      <= 2'b00;
      dig_valid <= 1'b0;
      dig_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      dig_valid <= 1'b0;
      dig_last  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            sh          <= mult;
            mode_signed <= is_signed;
            carry       <= 1'b0;
            cnt         <= '0;
            rc_m        <= mult[1:0];
            ready       <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          dig_valid <= 1'b1;
          dig_idx   <= cnt;
          sh        <= sh >> 2;
          cnt       <= cnt + 1'b1;
          if (last_slice) begin
            if (need_fix) begin
              // Unsigned adds +1 (m=00, c=1); signed adds -1 (m=11, c=0).
              rc_m  <= mode_signed ? 2'b11 : 2'b00;
              carry <= !mode_signed;
              state <= EXTRA;
            end else begin
              rc_m     <= 2'b00;
              carry    <= 1'b0;
              dig_last <= 1'b1;
              done     <= 1'b1;
              state    <= DRAIN;
            end
          end else begin
            rc_m  <= sh[3:2];
            carry <= rc_c_out;
          end
        end
        EXTRA: begin
          dig_valid <= 1'b1;
          dig_idx   <= cnt;
          dig_last  <= 1'b1;
          done      <= 1'b1;
          rc_m      <= 2'b00;
          carry     <= 1'b0;
          state     <= DRAIN;
        end
        DRAIN: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// Self-checking bench for booth_digit_sequencer: models the recoder cell and compares the
// digit stream against an arithmetic radix-4 expansion of the multiplier.
module tb_booth_digit_sequencer;

  localparam int N  = 8;
  localparam int IW = $clog2(N/2+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_signed;
  logic [N-1:0]  mult;
  logic          abort;
  logic          ready;
  logic          busy;
  logic [1:0]    rc_m;
  logic          rc_c_in;
  logic          rc_c_out;
  logic          rc_one;
  logic          rc_neg;
  logic          rc_zero;
  logic          dig_valid;
  logic          dig_one;
  logic          dig_neg;
  logic          dig_zero;
  logic [IW-1:0] dig_idx;
  logic          dig_last;
  logic          done;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  booth_digit_sequencer #(.N(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .mult(mult),
    .abort(abort), .ready(ready), .busy(busy), .rc_m(rc_m), .rc_c_in(rc_c_in),
    .rc_c_out(rc_c_out), .rc_one(rc_one), .rc_neg(rc_neg), .rc_zero(rc_zero),
    .dig_valid(dig_valid), .dig_one(dig_one), .dig_neg(dig_neg), .dig_zero(dig_zero),
    .dig_idx(dig_idx), .dig_last(dig_last), .done(done)
  );

  // Recoder cell: v = m + c_in; v in {3,4} borrows from the next digit (carry 1).
  logic [2:0] rv;
  assign rv       = {1'b0, rc_m} + {2'b00, rc_c_in};
  assign rc_c_out = (rv >= 3'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_one <= 1'b0; rc_neg <= 1'b0; rc_zero <= 1'b0;
    end else begin
      case (rv)
        3'd0:    begin rc_one <= 1'b0; rc_neg <= 1'b0; rc_zero <= 1'b1; end
        3'd1:    begin rc_one <= 1'b1; rc_neg <= 1'b0; rc_zero <= 1'b0; end
        3'd2:    begin rc_one <= 1'b0; rc_neg <= 1'b0; rc_zero <= 1'b0; end
        3'd3:    begin rc_one <= 1'b1; rc_neg <= 1'b1; rc_zero <= 1'b0; end
        default: begin rc_one <= 1'b0; rc_neg <= 1'b1; rc_zero <= 1'b1; end
      endcase
    end
  end

  function automatic longint op_value(input logic [N-1:0] m, input bit s);
    longint u;
    u = longint'(m);
    if (s && m[N-1]) u = u - (longint'(1) << N);
    return u;
  endfunction

  // Expected digits: repeatedly take x mod 4 with residue 3 mapped to -1, then divide.
  task automatic build_exp(input logic [N-1:0] m, input bit s);
    longint x;
    longint r;
    longint d;
    exp_q.delete();
    x = op_value(m, s);
    for (int i = 0; i < N/2; i++) begin
      r = x & 3;
      d = (r == 3) ? -1 : r;
      exp_q.push_back(int'(d));
      x = (x - d) / 4;
    end
    if (x != 0) exp_q.push_back(int'(x));
  endtask

  function automatic int decode(input logic one, input logic neg, input logic zero);
    int mag;
    if (zero) return 0;
    mag = one ? 1 : 2;
    return neg ? -mag : mag;
  endfunction

  // Starts an operation in the current cycle and follows it until ready returns.
  // Returns at the negedge of the cycle in which ready is 1 again.
  task automatic run_op(input logic [N-1:0] m, input bit s, input bit poke, input string name);
    int     j;
    bit     fin;
    longint sum;
    int     v;
    build_exp(m, s);
    start = 1'b1; is_signed = s; mult = m;
    @(posedge clk); #1;
    start = 1'b0; mult = N'($urandom); is_signed = 1'($urandom);
    j = 0; fin = 0; sum = 0;
    for (int k = 1; k <= 12 && !fin; k++) begin
      @(negedge clk);
      if (j == exp_q.size()) begin
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || k != j + 2) begin
          bad++;
          $display("FAIL %s ready_return: cycle=%0d ready=%b busy=%b want cycle=%0d ready=1 busy=0",
                   name, k, ready, busy, j + 2);
        end
        fin = 1;
      end else if (dig_valid === 1'b1) begin
        v = decode(dig_one, dig_neg, dig_zero);
        sum += longint'(v) <<< (2 * j);
        total++;
        if (k != j + 2 || dig_idx !== IW'(j) || v != exp_q[j] ||
            dig_last !== (j == exp_q.size() - 1) || done !== (j == exp_q.size() - 1) ||
            busy !== 1'b1) begin
          bad++;
          $display("FAIL %s digit%0d: cycle=%0d idx=%0d val=%0d last=%b done=%b busy=%b want cycle=%0d idx=%0d val=%0d last=%b",
                   name, j, k, dig_idx, v, dig_last, done, busy, j + 2, j, exp_q[j],
                   (j == exp_q.size() - 1));
        end
        j++;
      end else begin
        total++;
        if (k >= 2 || done !== 1'b0 || ready !== 1'b0) begin
          bad++;
          $display("FAIL %s no_digit: cycle=%0d done=%b ready=%b want digit %0d at cycle %0d",
                   name, k, done, ready, j, j + 2);
        end
      end
      if (poke && k == 2) begin start = 1'b1; mult = ~m; is_signed = ~s; end
      if (poke && k == 3) start = 1'b0;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL %s timeout: got %0d digits, want %0d and ready", name, j, exp_q.size());
    end
    total++;
    if (sum != op_value(m, s)) begin
      bad++;
      $display("FAIL %s sum: got %0d want %0d", name, sum, op_value(m, s));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; is_signed = 1'b0; mult = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || dig_valid !== 1'b0 ||
        dig_last !== 1'b0 || dig_idx !== '0 || rc_m !== 2'b00 || rc_c_in !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b busy=%b done=%b valid=%b last=%b idx=%0d rc_m=%b c_in=%b want 1 0 0 0 0 0 00 0",
               ready, busy, done, dig_valid, dig_last, dig_idx, rc_m, rc_c_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8'hFF, 1'b0, 1'b0, "uns_ff");
    run_op(8'hFF, 1'b1, 1'b0, "sgn_ff");
    run_op(8'h96, 1'b1, 1'b0, "sgn_96");
    run_op(8'h96, 1'b0, 1'b0, "uns_96");
    run_op(8'h00, 1'b0, 1'b0, "zero");
    run_op(8'h80, 1'b1, 1'b0, "sgn_80");
  endtask

  task automatic test_start_ignored();
    run_op(8'h5A, 1'b0, 1'b1, "poke_uns");
    run_op(8'hC3, 1'b1, 1'b1, "poke_sgn");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      run_op(N'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), "rand");
  endtask

  task automatic test_abort(input bit use_rst);
    string name;
    name = use_rst ? "rst_mid" : "abort_mid";
    start = 1'b1; is_signed = 1'($urandom); mult = N'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || dig_valid !== 1'b0 || done !== 1'b0 ||
        rc_m !== 2'b00 || rc_c_in !== 1'b0) begin
      bad++;
      $display("FAIL %s after: ready=%b busy=%b valid=%b done=%b rc_m=%b c_in=%b want 1 0 0 0 00 0",
               name, ready, busy, dig_valid, done, rc_m, rc_c_in);
    end
    if (use_rst) begin
      total++;
      if (dig_last !== 1'b0 || dig_idx !== '0 || dig_one !== 1'b0 || dig_neg !== 1'b0 ||
          dig_zero !== 1'b0) begin
        bad++;
        $display("FAIL %s reset_vals: last=%b idx=%0d one=%b neg=%b zero=%b want all 0",
                 name, dig_last, dig_idx, dig_one, dig_neg, dig_zero);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (dig_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
        bad++;
        $display("FAIL %s quiet%0d: valid=%b done=%b ready=%b want 0 0 1",
                 name, k, dig_valid, done, ready);
      end
    end
    run_op(8'h96, 1'b1, 1'b0, use_rst ? "after_rst" : "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
